rx_msg_buffer: RTL
==================

// Module: rx_msg_buffer
// PURPOSE
//  Receive-side message buffer downstream of mod_hi_speed_protocol_rx. Serves its RAM write
//  request/ready handshake and stores payload bytes in on-chip RAM. Commits each correctly
//  received message (flag, length, line) to a single-entry holding slot. Local logic reads
//  the held message and releases it; anything that cannot be stored intact is dropped and counted.
// PARAMETERS
//  ADDR_W   10   buffer depth = 2**ADDR_W bytes; RAM index = wr_addr[ADDR_W-1:0]
// PORTS
//  clk           in   1       system clock (bb_clk_in domain)
//  rst_l         in   1       asynchronous active-low reset
//  wr_req        in   1       RX_RAM_REQ_WR: level; wr_addr/wr_data stable while high
//  wr_rdy        out  1       RX_RAM_RDY_WR: one-cycle ack pulse per request
//  wr_addr       in   16      RX_RAM_ADDR_OUT
//  wr_data       in   8       RX_RAM_DATA_OUT
//  rx_hdr_en     in   1       RX_FLAG_BYTE_NUMBER_RD_EN pulse: flag/length valid
//  rx_flag       in   8       RX_FLAG
//  rx_byte_num   in   16      RX_BYTE_NUMBER
//  rx_end        in   1       RX_END_MESSAGE pulse
//  rx_right      in   1       RX_MESSAGE_RIGHT, valid with rx_end
//  rx_line       in   1       RX_END_MESSAGE_LINE, valid with rx_end (0=COM1, 1=COM2)
//  rd_addr       in   ADDR_W  payload read address
//  rd_data       out  8       registered RAM output, 1-cycle read latency
//  msg_valid     out  1       holding slot occupied (buffer locked)
//  msg_flag      out  8       committed flag
//  msg_len       out  16      committed byte count
//  msg_line      out  1       committed receive line
//  msg_release   in   1       pulse: free the slot
//  drop_cnt      out  8       messages lost to lock/overflow, saturates at 255
//  bad_cnt       out  8       messages ended with rx_right=0, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; shadow regs and taint cleared. RAM contents not reset.
//  Write FSM, states IDLE -> ACK -> WAIT_LOW -> IDLE:
//   IDLE: wr_req=1 sampled at edge N -> write performed at edge N, go ACK.
//   ACK: wr_rdy=1 for exactly this cycle (N..N+1); go WAIT_LOW.
//   WAIT_LOW: wr_rdy=0; stay until wr_req=0, then IDLE. Held req is never acked twice.
//   Back-to-back: req drops and rises again -> next ack 3 cycles after the previous one, minimum.
//  Write is discarded but still acked if msg_valid=1, or wr_addr >= 2**ADDR_W. Any discard sets taint.
//  rx_hdr_en: latch rx_flag/rx_byte_num into shadow regs; clear taint;
//   set taint if rx_byte_num > 2**ADDR_W.
//  rx_end with !rx_right: bad_cnt+1; nothing committed; taint cleared.
//  rx_end with rx_right and (taint or msg_valid): drop_cnt+1; taint cleared.
//  rx_end with rx_right, !taint, !msg_valid: next cycle msg_valid=1;
//   msg_flag/msg_len = shadow; msg_line = rx_line.
//  rx_end in the same cycle as the final write-FSM sample: the write completes first, so the commit is intact.
//  msg_release: msg_valid=0 next cycle. Release with msg_valid=0 has no effect.
//  Release and rx_end in the same cycle: rx_end uses the pre-release lock (=1), so the message is dropped;
//   release still takes effect.
//  rd_data = RAM[rd_addr] registered; RAM is simple dual-port (write via FSM, read via rd_addr).
//  Counters saturate; they never wrap. Cleared only by reset.
//  Reset asserted mid-handshake: wr_rdy drops immediately; FSM returns to IDLE.
//   A still-high wr_req after reset release is treated as a new request.
// TESTING
//  1. Hdr(flag=8'h5A, len=4), writes a0..a3 = 11,22,33,44, rx_end/right=1/line=1
//     -> msg_valid=1, flag=5A, len=4, line=1; rd 0..3 = 11,22,33,44.
//  2. Hold wr_req high 10 cycles -> exactly one wr_rdy pulse, 1 cycle after req seen.
//  3. While msg_valid=1, a second message of 2 bytes -> both acked, RAM unchanged, drop_cnt=1.
//  4. rx_end with rx_right=0 -> bad_cnt=1, msg_valid stays 0. 300 bad messages -> bad_cnt=255.
//  5. wr_addr=16'h0400 (ADDR_W=10) -> acked, no write; that message's rx_end -> drop_cnt+1.
//  6. Assert rst_l=0 during ACK -> wr_rdy=0 asynchronously; all counters and msg_valid = 0.

Source files
------------

// File: rtl/rx_msg_buffer.sv
// rx_msg_buffer: payload RAM behind the RX write handshake, with a single-entry slot holding the committed message.
module rx_msg_buffer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              wr_req,
    output logic              wr_rdy,
    input  logic [15:0]       wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rx_hdr_en,
    input  logic [7:0]        rx_flag,
    input  logic [15:0]       rx_byte_num,
    input  logic              rx_end,
    input  logic              rx_right,
    input  logic              rx_line,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              msg_valid,
    output logic [7:0]        msg_flag,
    output logic [15:0]       msg_len,
    output logic              msg_line,
    input  logic              msg_release,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        bad_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    state_t     state;
    logic [7:0] ram [DEPTH];
    logic [7:0] sh_flag;
    logic [15:0] sh_len;
    logic       taint, sample, discard, dirty, commit;
    always_comb begin
        sample  = state == IDLE && wr_req;
        discard = sample && (msg_valid || 32'(wr_addr) >= DEPTH);
        // a discard in the same cycle as rx_end must still spoil that message
        dirty   = taint || discard;
        commit  = rx_end && rx_right && !dirty && !msg_valid;
    end
    always_ff @(posedge clk)
        if (sample && !discard) ram[wr_addr[ADDR_W-1:0]] <= wr_data;
    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            state     <= IDLE;
            wr_rdy    <= 1'b0;
            rd_data   <= '0;
            sh_flag   <= '0;
            sh_len    <= '0;
            taint     <= 1'b0;
            msg_valid <= 1'b0;
            msg_flag  <= '0;
            msg_len   <= '0;
            msg_line  <= 1'b0;
            drop_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            state   <= sample ? ACK : state == ACK ? WAIT_LOW : (state == WAIT_LOW && !wr_req) ? IDLE : state;
            wr_rdy  <= sample;
            rd_data <= ram[rd_addr];
            if (rx_hdr_en) begin
                sh_flag <= rx_flag;
                sh_len  <= rx_byte_num;
            end
            taint <= rx_end ? 1'b0 : rx_hdr_en ? (32'(rx_byte_num) > DEPTH) || discard : dirty;
            if (rx_end && !rx_right && bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
            if (rx_end && rx_right && (dirty || msg_valid) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (commit) begin
                msg_valid <= 1'b1;
                msg_flag  <= sh_flag;
                msg_len   <= sh_len;
                msg_line  <= rx_line;
            end else if (msg_release) begin
                msg_valid <= 1'b0;
            end
        end
endmodule
